// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// Imported by the FIFO and the serializer top.
package serializer_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic IDLE_BIT_DEF = 1'b0;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel word handshake into the serializer.
// The producer drives the master side.
interface bit_serializer_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );

endinterface

// File: rtl/bit_serializer_fifo.sv
// Small circular-buffer FIFO holding words awaiting serialization.
// Head word is presented combinationally on dout.
module word_fifo
    import serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: FIFO-buffered words shifted out one bit per clock.
// Consecutive words reload on the last-bit edge so the stream has no gaps.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   DEPTH     = 2,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    bit_serializer_if.slave  in_if,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    state_t                 state_q;
    state_t                 state_d;
    logic [WIDTH-1:0]       shreg_q;
    logic [WIDTH-1:0]       shreg_d;
    logic [WIDTH-1:0]       shifted;
    logic [CW-1:0]          bitcnt_q;
    logic [CW-1:0]          bitcnt_d;
    logic                   last;
    logic                   push;
    logic                   pop;
    logic [WIDTH-1:0]       head;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;

    assign in_if.din_ready = !full && !reset;
    assign push            = in_if.din_valid && in_if.din_ready;

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (in_if.din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign last    = (bitcnt_q == CW'(WIDTH-1));
    assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shreg_d  = head;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (!last) begin
                    shreg_d  = shifted;
                    bitcnt_d = bitcnt_q + 1'b1;
                end else if (!empty) begin
                    // back-to-back reload keeps sout_valid high
                    pop      = 1'b1;
                    shreg_d  = head;
                    bitcnt_d = '0;
                end else begin
                    shreg_d  = '0;
                    bitcnt_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sout_valid = (state_q == SHIFT);
    assign word_done  = sout_valid && last;
    assign busy       = sout_valid || (count != '0);
    assign sout       = !sout_valid ? IDLE_BIT
                      : (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB- and LSB-first serializers against a bit-schedule model.
// Directed literal patterns pin the model; random traffic exercises the rest.
module tb_bit_serializer;
    import serializer_pkg::*;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int NE = 4096;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] din = '0;
    logic         dv = 1'b0;

    logic so_m, sv_m, wd_m, bz_m;
    logic so_l, sv_l, wd_l, bz_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(W)) im ();
    bit_serializer_if #(.WIDTH(W)) il ();

    assign im.din       = din;
    assign im.din_valid = dv;
    assign il.din       = din;
    assign il.din_valid = dv;

    bit_serializer #(
        .WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
    ) dut_m (
        .clk(clk), .reset(reset), .in_if(im),
        .sout(so_m), .sout_valid(sv_m), .word_done(wd_m), .busy(bz_m)
    );

    bit_serializer #(
        .WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)
    ) dut_l (
        .clk(clk), .reset(reset), .in_if(il),
        .sout(so_l), .sout_valid(sv_l), .word_done(wd_l), .busy(bz_l)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, got, expv);
        end
    endtask

    // Model: each accepted word is scheduled onto absolute edge slots.
    int e = 0;
    int last_end = 0;
    int starts[$];
    bit mv[NE];
    bit mbm[NE];
    bit mbl[NE];
    bit md[NE];

    task automatic model_step();
        int s;
        e++;
        if (reset) begin
            for (int i = e; i < e + 64; i++) begin
                mv[i] = 1'b0; mbm[i] = 1'b0; mbl[i] = 1'b0; md[i] = 1'b0;
            end
            starts.delete();
            last_end = 0;
        end else if (dv && starts.size() < D) begin
            s = (e + 1 > last_end) ? e + 1 : last_end;
            for (int i = 0; i < W; i++) begin
                mv[s+i]  = 1'b1;
                mbm[s+i] = din[W-1-i];
                mbl[s+i] = din[i];
                md[s+i]  = (i == W - 1);
            end
            last_end = s + W;
            starts.push_back(s);
        end
        while (starts.size() > 0 && starts[0] <= e) void'(starts.pop_front());
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        logic rdy, bsy;
        @(negedge clk);
        if (e > 0) begin
            rdy = !reset && (starts.size() < D);
            bsy = (starts.size() > 0) || mv[e];
            chk("outs_msb", {im.din_ready, bz_m, sv_m, wd_m, so_m},
                {rdy, bsy, mv[e], md[e], mv[e] ? mbm[e] : 1'b0});
            chk("outs_lsb", {il.din_ready, bz_l, sv_l, wd_l, so_l},
                {rdy, bsy, mv[e], md[e], mv[e] ? mbl[e] : 1'b0});
        end
    end

    bit log[$];
    int ndone = 0;

    initial forever begin
        @(negedge clk);
        if (sv_m) log.push_back(so_m);
        if (wd_m) ndone++;
    end

    initial begin
        logic [7:0]  pat;
        logic [23:0] exp24;
        int thr;

        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("idle_ready", im.din_ready, 1);
            chk("idle_outs", {sv_m, so_m, bz_m}, 0);
        end

        pat = 8'b0111_1100;
        @(negedge clk); #2 din = pat; dv = 1'b1;
        @(negedge clk); #2 dv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("p7c_bit", so_m, pat[7-i]);
            chk("p7c_done", wd_m, (i == 7));
        end
        @(negedge clk);
        chk("p7c_idle", {sv_m, so_m}, 0);

        @(negedge clk); #2 din = 8'h01; dv = 1'b1;
        @(negedge clk); #2 dv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("lsb_bit", so_l, (i == 0));
        end

        @(negedge clk); #2;
        log.delete(); ndone = 0;
        exp24 = {8'hA5, 8'h3C, 8'hFF};
        din = 8'hA5; dv = 1'b1;
        @(negedge clk); #2 din = 8'h3C;
        @(negedge clk); #2 din = 8'hFF;
        @(negedge clk);
        chk("full_ready", im.din_ready, 0);
        #2 dv = 1'b0;
        repeat (30) @(negedge clk);
        chk("burst_len", log.size(), 24);
        for (int i = 0; i < 24 && i < log.size(); i++)
            chk("burst_bit", log[i], exp24[23-i]);
        chk("burst_done", ndone, 3);

        @(negedge clk); #2 din = 8'hF0; dv = 1'b1;
        @(negedge clk); #2 din = 8'h0F;
        @(negedge clk); #2 dv = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bit3", so_m, 1);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_outs", {sv_m, so_m, wd_m, bz_m}, 0);
        #2 reset = 1'b0;
        log.delete(); ndone = 0;
        repeat (20) @(negedge clk);
        chk("rst_drop", log.size(), 0);
        chk("rst_nodone", ndone, 0);

        for (int ph = 0; ph < 5; ph++) begin
            thr = $urandom_range(1, 16);
            repeat (100) begin
                @(negedge clk); #2;
                reset = ($urandom_range(0, 99) == 0);
                dv    = ($urandom_range(0, 15) < thr);
                din   = W'($urandom);
            end
        end
        @(negedge clk); #2 dv = 1'b0; reset = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
